bitserial_adder_ctrl: RTL and testbench

//   Sequences one shared full-adder cell over the bits of two operands taken from SW[7:0]
//   (A=SW[3:0], B=SW[7:4]) plus CIN, producing a WIDTH-bit sum and carry-out.

---
 rtl/bitserial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_bitserial_adder_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell applied to A/B one bit per step, result held on LED/7-seg.
// Optional `SUBTRACT_EN adds a SUB input that turns the operation into A-B (two's complement).
module bitserial_adder_ctrl #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] SW,
  input  logic               CIN,
  input  logic               START,
  input  logic               FLIP,
`ifdef SUBTRACT_EN
  input  logic               SUB,
`endif
  output logic               BUSY,
  output logic               DONE,
  output logic [WIDTH:0]     LED,
  output logic [6:0]         SLED0,
  output logic [6:0]         SLED1,
  output logic [6:0]         SLED2,
  output logic [6:0]         SLED3,
  output logic [6:0]         SLED4,
  output logic [1:0]         STATE_DBG
);

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;
  localparam logic [6:0] SEG_ONE   = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_SUM   = 7'b0100100;
  localparam logic [6:0] SEG_CARRY = 7'b0110001;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic             r_start_q;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [DW-1:0]    r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   r_led;

  logic             w_edge;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_load_b;
  logic             w_load_c;

  assign w_edge = START & ~r_start_q;
  assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

`ifdef SUBTRACT_EN
  // A-B is A + ~B + 1; CIN is deliberately ignored in this mode.
  assign w_load_b = SUB ? ~SW[2*WIDTH-1:WIDTH] : SW[2*WIDTH-1:WIDTH];
  assign w_load_c = SUB ? 1'b1 : CIN;
`else
  assign w_load_b = SW[2*WIDTH-1:WIDTH];
  assign w_load_c = CIN;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_led     <= '0;
    end else begin
      r_start_q <= START;
      r_done    <= 1'b0;
      case (r_state)
        S_ADD: begin
          if (r_div == DW'(STEP_DIV - 1)) begin
            r_div    <= '0;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= w_c;
            r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_led   <= {w_c, w_s, r_sum_sh[WIDTH-1:1]};
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        default: begin
          // IDLE and the single DONE cycle both accept a new request.
          if (w_edge) begin
            r_a_sh  <= SW[WIDTH-1:0];
            r_b_sh  <= w_load_b;
            r_carry <= w_load_c;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign LED       = r_led;
  assign STATE_DBG = r_state;

  always_comb begin
    SLED0 = SEG_ZERO;
    SLED1 = SEG_ZERO;
    SLED2 = SEG_ZERO;
    SLED3 = SEG_ZERO;
    SLED4 = SEG_SUM;
    if (FLIP) begin
      SLED0 = r_led[WIDTH] ? SEG_ONE : SEG_ZERO;
      SLED1 = SEG_BLANK;
      SLED2 = SEG_BLANK;
      SLED3 = SEG_BLANK;
      SLED4 = SEG_CARRY;
    end else begin
      SLED0 = r_led[0] ? SEG_ONE : SEG_ZERO;
      SLED1 = r_led[1] ? SEG_ONE : SEG_ZERO;
      SLED2 = r_led[2] ? SEG_ONE : SEG_ZERO;
      SLED3 = r_led[3] ? SEG_ONE : SEG_ZERO;
    end
  end

endmodule

// File: tb/tb_bitserial_adder_ctrl.sv
// Self-checking bench for bitserial_adder_ctrl: arithmetic reference model, two instances (STEP_DIV 1 and 3).
module tb_bitserial_adder_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SW = 8'h00;
  logic       CIN = 1'b0;
  logic       START = 1'b0;
  logic       FLIP = 1'b0;
  logic       SUB = 1'b0;

  logic       busy1, done1, busy3, done3;
  logic [4:0] led1, led3;
  logic [6:0] s1_0, s1_1, s1_2, s1_3, s1_4;
  logic [6:0] s3_0, s3_1, s3_2, s3_3, s3_4;
  logic [1:0] st1, st3;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  always #5 CLK = ~CLK;

  bitserial_adder_ctrl #(.WIDTH(4), .STEP_DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .SW(SW), .CIN(CIN), .START(START), .FLIP(FLIP),
`ifdef SUBTRACT_EN
    .SUB(SUB),
`endif
    .BUSY(busy1), .DONE(done1), .LED(led1),
    .SLED0(s1_0), .SLED1(s1_1), .SLED2(s1_2), .SLED3(s1_3), .SLED4(s1_4),
    .STATE_DBG(st1)
  );

  bitserial_adder_ctrl #(.WIDTH(4), .STEP_DIV(3)) dut3 (
    .CLK(CLK), .RST(RST), .SW(SW), .CIN(CIN), .START(START), .FLIP(FLIP),
`ifdef SUBTRACT_EN
    .SUB(SUB),
`endif
    .BUSY(busy3), .DONE(done3), .LED(led3),
    .SLED0(s3_0), .SLED1(s3_1), .SLED2(s3_2), .SLED3(s3_3), .SLED4(s3_4),
    .STATE_DBG(st3)
  );

  // Reference model: plain arithmetic and display lookup.
  function automatic logic [4:0] model_add(input logic [7:0] sw, input logic cin);
    int total;
    total = int'(sw[3:0]) + int'(sw[7:4]) + int'(cin);
    return total[4:0];
  endfunction

  function automatic logic [6:0] digit(input logic b);
    return b ? 7'b1001111 : 7'b0000001;
  endfunction

  function automatic logic [34:0] model_disp(input logic [4:0] led, input logic flip);
    if (flip) return {7'b0110001, 7'b1111111, 7'b1111111, 7'b1111111, digit(led[4])};
    return {7'b0100100, digit(led[3]), digit(led[2]), digit(led[1]), digit(led[0])};
  endfunction

  // Drive a START rising edge with new operands; returns #1 after the capturing edge.
  task automatic start_op(input logic [7:0] sw, input logic cin);
    @(negedge CLK);
    SW = sw;
    CIN = cin;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Cycles from capture to DONE on the chosen instance; 0 means timeout.
  task automatic wait_done(input bit slow, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if ((slow ? done3 : done1) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [34:0] d;
    RST = 1'b1;
    FLIP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    d = {s1_4, s1_3, s1_2, s1_1, s1_0};
    n_checks++;
    if (led1 !== 5'b00000) begin n_errors++; $display("FAIL reset_led got %b want 00000", led1); end
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_errors++; $display("FAIL reset_busy_done got %b%b want 00", busy1, done1); end
    n_checks++;
    if (d !== model_disp(5'b0, 1'b0)) begin n_errors++; $display("FAIL reset_disp got %h want %h", d, model_disp(5'b0, 1'b0)); end
    n_checks++;
    if (led3 !== 5'b00000 || busy3 !== 1'b0) begin n_errors++; $display("FAIL reset_slow got %b/%b want 00000/0", led3, busy3); end
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic();
    int cyc;
    logic bad_hold;
    logic [4:0] prev;
    logic [34:0] d;
    prev = led1;
    bad_hold = 1'b0;
    start_op(8'h53, 1'b0);
    n_checks++;
    if (busy1 !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b want 1", busy1); end
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (done1 === 1'b1) begin cyc = i; break; end
      if (led1 !== prev) bad_hold = 1'b1;
    end
    n_checks++;
    if (cyc != 4) begin n_errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
    n_checks++;
    if (bad_hold) begin n_errors++; $display("FAIL basic_led_hold got changed want %b", prev); end
    n_checks++;
    if (led1 !== 5'b01000) begin n_errors++; $display("FAIL basic_led got %b want 01000", led1); end
    d = {s1_4, s1_3, s1_2, s1_1, s1_0};
    n_checks++;
    if (d !== {7'b0100100, 7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001}) begin
      n_errors++; $display("FAIL basic_disp got %h want sum view of 01000", d);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_errors++; $display("FAIL basic_done_width got %b%b want 00", done1, busy1); end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [34:0] d;
    start_op(8'h1F, 1'b0);
    wait_done(1'b0, cyc);
    n_checks++;
    if (cyc != 4) begin n_errors++; $display("FAIL ovf_latency got %0d want 4", cyc); end
    n_checks++;
    if (led1 !== 5'b10000) begin n_errors++; $display("FAIL ovf_led got %b want 10000", led1); end
    FLIP = 1'b1;
    #1;
    d = {s1_4, s1_3, s1_2, s1_1, s1_0};
    n_checks++;
    if (d !== {7'b0110001, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1001111}) begin
      n_errors++; $display("FAIL ovf_flip_disp got %h want carry view with 1", d);
    end
    FLIP = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] sw;
    logic cin;
    logic [4:0] e;
    logic [34:0] d;
    for (int n = 0; n < 24; n++) begin
      sw = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      exp_q.push_back(model_add(sw, cin));
      start_op(sw, cin);
      // Display follows FLIP immediately, even mid-addition.
      FLIP = 1'($urandom_range(0, 1));
      #1;
      d = {s1_4, s1_3, s1_2, s1_1, s1_0};
      n_checks++;
      if (d !== model_disp(led1, FLIP)) begin n_errors++; $display("FAIL rand_disp_busy[%0d] got %h want %h", n, d, model_disp(led1, FLIP)); end
      wait_done(1'b0, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 4 || led1 !== e) begin
        n_errors++; $display("FAIL rand_add[%0d] sw=%h cin=%b got led=%b cyc=%0d want led=%b cyc=4", n, sw, cin, led1, cyc, e);
      end
      d = {s1_4, s1_3, s1_2, s1_1, s1_0};
      n_checks++;
      if (d !== model_disp(e, FLIP)) begin n_errors++; $display("FAIL rand_disp[%0d] got %h want %h", n, d, model_disp(e, FLIP)); end
      // Some operations start in the DONE cycle itself, the rest after an idle gap.
      if (n % 3 != 0) repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    FLIP = 1'b0;
  endtask

  task automatic test_ignore();
    int n_done;
    logic [4:0] e;
    e = model_add(8'h94, 1'b1);
    start_op(8'h94, 1'b1);
    n_done = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge CLK);
      if (i == 1) begin SW = 8'hFF; CIN = 1'b0; end
      if (i == 2) START = 1'b1;
      if (done1 === 1'b1) begin
        n_done++;
        n_checks++;
        if (led1 !== e) begin n_errors++; $display("FAIL ignore_led got %b want %b", led1, e); end
      end
    end
    START = 1'b0;
    n_checks++;
    if (n_done != 1) begin n_errors++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
    n_checks++;
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL ignore_idle got busy=%b want 0", busy1); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    start_op(8'h21, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if (led1 !== 5'b00000 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid got led=%b busy=%b done=%b want 00000/0/0", led1, busy1, done1);
    end
    @(negedge CLK);
    RST = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (done1 === 1'b1 || done3 === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin n_errors++; $display("FAIL rst_mid_no_done got %0d want 0", n_done); end
  endtask

  task automatic test_step_div();
    int cyc;
    start_op(8'h77, 1'b1);
    wait_done(1'b1, cyc);
    n_checks++;
    if (cyc != 12) begin n_errors++; $display("FAIL stepdiv_latency got %0d want 12", cyc); end
    n_checks++;
    if (led3 !== 5'b01111) begin n_errors++; $display("FAIL stepdiv_led got %b want 01111", led3); end
    repeat (2) @(negedge CLK);
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract();
    int cyc;
    SUB = 1'b1;
    start_op(8'h35, 1'b0);
    wait_done(1'b0, cyc);
    n_checks++;
    if (led1 !== 5'b10010) begin n_errors++; $display("FAIL sub_5m3 got %b want 10010", led1); end
    start_op(8'h53, 1'b1);
    wait_done(1'b0, cyc);
    n_checks++;
    if (led1 !== 5'b01110) begin n_errors++; $display("FAIL sub_3m5 got %b want 01110", led1); end
    SUB = 1'b0;
    repeat (2) @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_ignore();
    test_reset_mid();
    test_step_div();
`ifdef SUBTRACT_EN
    test_subtract();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
